// File: rtl/s100_sys_ctrl.sv
// S-100/Altair system controller: CPU phase enable, SYNC status latch, region/port decode,
// read-data mux and turn-key boot JMP. Optional wait states via macro WAITSTATE_EN.
module s100_sys_ctrl #(
  parameter int CE_DIV = 3,
  parameter int NUM_MEM = 4,
  parameter int NUM_IO = 2,
  parameter logic [8*NUM_MEM-1:0] MEM_BASE = {8'h00, 8'hFB, 8'hFD, 8'h00},
  parameter logic [8*NUM_MEM-1:0] MEM_MASK = {8'h00, 8'hFF, 8'hFF, 8'hE0},
  parameter logic [NUM_MEM-1:0] MEM_RO = 4'b0100,
  parameter logic [2*NUM_MEM-1:0] MEM_WS = 8'h00,
  parameter logic [8*NUM_IO-1:0] IO_BASE = {8'h10, 8'h00},
  parameter logic [8*NUM_IO-1:0] IO_MASK = {8'hFE, 8'hFE},
  parameter logic [15:0] BOOT_VECTOR = 16'hFD00
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ce,
  input  logic [15:0]          cpu_addr,
  input  logic [7:0]           cpu_dout,
  input  logic                 cpu_sync,
  input  logic                 cpu_dbin,
  input  logic                 cpu_wr_n,
  output logic [7:0]           cpu_din,
  output logic                 cpu_ready,
  output logic [NUM_MEM-1:0]   mem_rd,
  output logic [NUM_MEM-1:0]   mem_we,
  input  logic [8*NUM_MEM-1:0] mem_rdata,
  output logic [NUM_IO-1:0]    io_rd,
  output logic [NUM_IO-1:0]    io_we,
  input  logic [8*NUM_IO-1:0]  io_rdata,
  output logic [7:0]           status,
  output logic                 boot_active,
  output logic                 bus_err
);

  typedef enum logic [1:0] {B_OP, B_LO, B_HI, RUN} boot_t;

  localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [CW-1:0] CE_LAST = CW'(CE_DIV - 1);

  boot_t boot_q, boot_d;
  logic [CW-1:0] ce_cnt;
  logic dbin_q, wr_n_q, dbin_fall, run;
  logic [NUM_MEM-1:0] mem_match, mem_first;
  logic [NUM_IO-1:0] io_match, io_first;
  logic mem_hit, io_hit, ro_hit, wr_bad;
  logic [7:0] mem_sel_data, io_sel_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_cnt <= '0;
      ce     <= 1'b0;
    end else if (ce_cnt == CE_LAST) begin
      ce_cnt <= '0;
      ce     <= ~ce;
    end else begin
      ce_cnt <= ce_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status  <= 8'h00;
      dbin_q  <= 1'b0;
      wr_n_q  <= 1'b1;
      boot_q  <= B_OP;
      bus_err <= 1'b0;
    end else begin
      if (cpu_sync) status <= cpu_dout;
      dbin_q  <= cpu_dbin;
      wr_n_q  <= cpu_wr_n;
      boot_q  <= boot_d;
      bus_err <= wr_n_q & ~cpu_wr_n & wr_bad;
    end
  end

  assign dbin_fall   = dbin_q & ~cpu_dbin;
  assign run         = (boot_q == RUN);
  assign boot_active = ~run;

  always_comb begin
    boot_d = boot_q;
    case (boot_q)
      B_OP:    if (dbin_fall) boot_d = B_LO;
      B_LO:    if (dbin_fall) boot_d = B_HI;
      B_HI:    if (dbin_fall) boot_d = RUN;
      default: boot_d = RUN;
    endcase
  end

  // Lowest-index hit wins: isolate the least significant set match bit.
  always_comb begin
    for (int i = 0; i < NUM_MEM; i++)
      mem_match[i] = (cpu_addr[15:8] & MEM_MASK[8*i +: 8]) == MEM_BASE[8*i +: 8];
    for (int j = 0; j < NUM_IO; j++)
      io_match[j] = (cpu_addr[7:0] & IO_MASK[8*j +: 8]) == IO_BASE[8*j +: 8];
  end

  assign mem_first = mem_match & (~mem_match + NUM_MEM'(1));
  assign io_first  = io_match & (~io_match + NUM_IO'(1));
  assign mem_hit   = |mem_match;
  assign io_hit    = |io_match;
  assign ro_hit    = |(mem_first & MEM_RO);

  always_comb begin
    mem_sel_data = 8'h00;
    io_sel_data  = 8'h00;
    for (int i = 0; i < NUM_MEM; i++)
      if (mem_first[i]) mem_sel_data = mem_rdata[8*i +: 8];
    for (int j = 0; j < NUM_IO; j++)
      if (io_first[j]) io_sel_data = io_rdata[8*j +: 8];
  end

  // Strobes are level-qualified copies of cpu_dbin / ~cpu_wr_n on the single winning target.
  always_comb begin
    mem_rd  = '0;
    io_rd   = '0;
    cpu_din = 8'hFF;
    if (!run) begin
      case (boot_q)
        B_OP:    cpu_din = 8'hC3;
        B_LO:    cpu_din = BOOT_VECTOR[7:0];
        default: cpu_din = BOOT_VECTOR[15:8];
      endcase
    end else if (status[6]) begin
      io_rd = io_first & {NUM_IO{cpu_dbin}};
      if (io_hit) cpu_din = io_sel_data;
    end else begin
      mem_rd = mem_first & {NUM_MEM{cpu_dbin}};
      if (mem_hit) cpu_din = mem_sel_data;
    end
  end

  always_comb begin
    mem_we = '0;
    io_we  = '0;
    wr_bad = 1'b0;
    if (status[4]) begin
      io_we  = io_first & {NUM_IO{~cpu_wr_n}};
      wr_bad = ~io_hit;
    end else begin
      mem_we = mem_first & ~MEM_RO & {NUM_MEM{~cpu_wr_n}};
      wr_bad = ~mem_hit | ro_hit;
    end
  end

`ifdef WAITSTATE_EN
  logic [1:0] wait_cnt, ws_sel;
  logic ce_rise, sync_io;

  assign ce_rise = (ce_cnt == CE_LAST) & ~ce;
  assign sync_io = cpu_dout[6] | cpu_dout[4];

  always_comb begin
    ws_sel = 2'd0;
    for (int i = 0; i < NUM_MEM; i++)
      if (mem_first[i]) ws_sel = MEM_WS[2*i +: 2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 2'd0;
    else if (cpu_sync) wait_cnt <= (run && !sync_io && mem_hit) ? ws_sel : 2'd0;
    else if (ce_rise && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
  end

  assign cpu_ready = (wait_cnt == 2'd0);
`else
  assign cpu_ready = 1'b1;
`endif

endmodule

// File: tb/tb_s100_sys_ctrl.sv
// Bench for s100_sys_ctrl: directed checks of boot, decode and bus errors, then random traffic
// compared each cycle against a table-driven behavioural model.
module tb_s100_sys_ctrl;
  localparam int CE_DIV = 3;

  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_dout, cpu_din, status;
  logic cpu_sync, cpu_dbin, cpu_wr_n, ce, cpu_ready, boot_active, bus_err;
  logic [3:0] mem_rd, mem_we;
  logic [31:0] mem_rdata;
  logic [1:0] io_rd, io_we;
  logic [15:0] io_rdata;

  int total = 0, bad = 0;

  s100_sys_ctrl #(
    .CE_DIV(CE_DIV), .NUM_MEM(4), .NUM_IO(2),
    .MEM_BASE({8'h00, 8'hFD, 8'hFB, 8'h00}),
    .MEM_MASK({8'hC0, 8'hFF, 8'hFF, 8'hE0}),
    .MEM_RO(4'b0100), .MEM_WS(8'h08),
    .IO_BASE({8'h10, 8'h00}), .IO_MASK({8'hFE, 8'hFE}),
    .BOOT_VECTOR(16'hFD00)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_sync(cpu_sync), .cpu_dbin(cpu_dbin), .cpu_wr_n(cpu_wr_n), .cpu_din(cpu_din),
    .cpu_ready(cpu_ready), .mem_rd(mem_rd), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .io_rd(io_rd), .io_we(io_we), .io_rdata(io_rdata), .status(status),
    .boot_active(boot_active), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Model tables, region index order.
  logic [7:0] mem_base_t [4] = '{8'h00, 8'hFB, 8'hFD, 8'h00};
  logic [7:0] mem_mask_t [4] = '{8'hE0, 8'hFF, 8'hFF, 8'hC0};
  bit         mem_ro_t   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int         mem_ws_t   [4] = '{0, 2, 0, 0};
  logic [7:0] io_base_t  [2] = '{8'h00, 8'h10};
  logic [7:0] io_mask_t  [2] = '{8'hFE, 8'hFE};
  logic [7:0] boot_bytes [3] = '{8'hC3, 8'h00, 8'hFD};

  function automatic int mem_find(logic [7:0] pg);
    for (int i = 0; i < 4; i++) if ((pg & mem_mask_t[i]) == mem_base_t[i]) return i;
    return -1;
  endfunction

  function automatic int io_find(logic [7:0] pt);
    for (int i = 0; i < 2; i++) if ((pt & io_mask_t[i]) == io_base_t[i]) return i;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  int m_cyc, m_boot, m_wait;
  logic [7:0] m_status;
  bit m_prev_dbin, m_prev_wr_n, m_err;

  function automatic bit model_wr_bad();
    int t;
    if (m_status[4]) return io_find(cpu_addr[7:0]) < 0;
    t = mem_find(cpu_addr[15:8]);
    return (t < 0) || mem_ro_t[t];
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int t;
    bit rise;
    if (reset) begin
      m_cyc = 0; m_boot = 0; m_wait = 0; m_status = 8'h00;
      m_prev_dbin = 1'b0; m_prev_wr_n = 1'b1; m_err = 1'b0;
    end else begin
      rise = ((m_cyc + 1) % CE_DIV == 0) && ((m_cyc / CE_DIV) % 2 == 0);
      if (cpu_sync) begin
        t = mem_find(cpu_addr[15:8]);
        m_wait = (m_boot == 3 && !(cpu_dout[6] || cpu_dout[4]) && t >= 0) ? mem_ws_t[t] : 0;
      end else if (rise && m_wait > 0) begin
        m_wait--;
      end
      m_err = m_prev_wr_n && !cpu_wr_n && model_wr_bad();
      if (m_prev_dbin && !cpu_dbin && m_boot < 3) m_boot++;
      if (cpu_sync) m_status = cpu_dout;
      m_prev_dbin = cpu_dbin;
      m_prev_wr_n = cpu_wr_n;
      m_cyc++;
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] e_din;
    logic [3:0] e_mrd, e_mwe;
    logic [1:0] e_ird, e_iwe;
    int t, g;
    if (!reset) begin
      e_din = 8'hFF; e_mrd = 4'b0; e_mwe = 4'b0; e_ird = 2'b0; e_iwe = 2'b0;
      t = mem_find(cpu_addr[15:8]);
      g = io_find(cpu_addr[7:0]);
      if (m_boot < 3) begin
        e_din = boot_bytes[m_boot];
      end else if (m_status[6]) begin
        if (g >= 0) begin
          e_din = io_rdata[8*g +: 8];
          if (cpu_dbin) e_ird = 2'(1) << g;
        end
      end else if (t >= 0) begin
        e_din = mem_rdata[8*t +: 8];
        if (cpu_dbin) e_mrd = 4'(1) << t;
      end
      if (!cpu_wr_n) begin
        if (m_status[4]) begin
          if (g >= 0) e_iwe = 2'(1) << g;
        end else if (t >= 0 && !mem_ro_t[t]) begin
          e_mwe = 4'(1) << t;
        end
      end
      check("ce", ce, ((m_cyc / CE_DIV) % 2));
      check("status", status, m_status);
      check("boot_active", boot_active, m_boot < 3);
      check("cpu_din", cpu_din, e_din);
      check("mem_rd", mem_rd, e_mrd);
      check("mem_we", mem_we, e_mwe);
      check("io_rd", io_rd, e_ird);
      check("io_we", io_we, e_iwe);
      check("bus_err", bus_err, m_err);
`ifdef WAITSTATE_EN
      check("cpu_ready", cpu_ready, m_wait == 0);
`else
      check("cpu_ready", cpu_ready, 1'b1);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sync(logic [7:0] st, logic [15:0] a);
    tick();
    cpu_sync = 1'b1; cpu_dout = st; cpu_addr = a;
    tick();
    cpu_sync = 1'b0;
  endtask

  logic [7:0] pages [9] = '{8'h00, 8'h05, 8'h20, 8'h3F, 8'h40, 8'hFB, 8'hFD, 8'hFE, 8'h80};
  logic [7:0] ports [6] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h02, 8'hFF};
  logic [7:0] stats [8] = '{8'h80, 8'h00, 8'h10, 8'h40, 8'hA2, 8'h44, 8'hC0, 8'h50};
  bit ce_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    cpu_addr = 16'h0; cpu_dout = 8'h0; cpu_sync = 1'b0; cpu_dbin = 1'b0; cpu_wr_n = 1'b1;
    mem_rdata = 32'h44_33_A5_11; io_rdata = 16'h77_66;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ce", ce, 1'b0);
    check("rst_status", status, 8'h00);
    check("rst_boot_active", boot_active, 1'b1);
    check("rst_ready", cpu_ready, 1'b1);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_din", cpu_din, 8'hC3);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("ce_seq", ce, ce_tab[k]);
    end

    // One boot byte consumed, then reset restarts the sequence.
    tick(); cpu_dbin = 1'b1; cpu_addr = 16'(($urandom));
    @(negedge clk); check("boot0_pre", cpu_din, 8'hC3);
    tick(); cpu_dbin = 1'b0;
    tick();
    @(negedge clk); check("boot1_pre", cpu_din, 8'h00);
    tick(); reset = 1'b1;
    @(negedge clk); check("boot_restart", cpu_din, 8'hC3);
    tick(); tick(); reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      tick(); cpu_dbin = 1'b1; cpu_addr = 16'($urandom);
      @(negedge clk);
      check("boot_byte", cpu_din, boot_bytes[k]);
      check("boot_no_rd", mem_rd, 4'b0);
      check("boot_active_mid", boot_active, 1'b1);
      tick(); cpu_dbin = 1'b0;
    end
    tick();
    @(negedge clk); check("boot_done", boot_active, 1'b0);

    do_sync(8'h80, 16'h0000);
    cpu_addr = 16'hFB12; cpu_dbin = 1'b1;
    @(negedge clk); check("rd_fb12_strobe", mem_rd, 4'b0010); check("rd_fb12_data", cpu_din, 8'hA5);
    tick(); cpu_addr = 16'h4000;
    @(negedge clk); check("rd_4000_strobe", mem_rd, 4'b0000); check("rd_4000_data", cpu_din, 8'hFF);
    tick(); cpu_addr = 16'h0500;
    @(negedge clk); check("rd_overlap_strobe", mem_rd, 4'b0001); check("rd_overlap_data", cpu_din, 8'h11);
    tick(); cpu_addr = 16'h2500;
    @(negedge clk); check("rd_r3_strobe", mem_rd, 4'b1000); check("rd_r3_data", cpu_din, 8'h44);
    tick(); cpu_dbin = 1'b0;

    do_sync(8'h00, 16'h0000);
    cpu_addr = 16'hFD00; cpu_wr_n = 1'b0;
    @(negedge clk); check("wr_ro_we", mem_we, 4'b0);
    tick(); @(negedge clk); check("wr_ro_err", bus_err, 1'b1);
    tick(); @(negedge clk); check("wr_ro_err_end", bus_err, 1'b0);
    tick(); cpu_wr_n = 1'b1;
    tick(); cpu_addr = 16'hFB00; cpu_wr_n = 1'b0;
    @(negedge clk); check("wr_rw_we", mem_we, 4'b0010);
    tick(); @(negedge clk); check("wr_rw_err", bus_err, 1'b0);
    tick(); cpu_wr_n = 1'b1;

    do_sync(8'h10, 16'h0000);
    cpu_addr = 16'h1111; cpu_wr_n = 1'b0;
    @(negedge clk); check("io_we_1111", io_we, 2'b10);
    tick(); cpu_wr_n = 1'b1;
    tick(); cpu_addr = 16'h0202; cpu_wr_n = 1'b0;
    @(negedge clk); check("io_we_0202", io_we, 2'b00);
    tick(); @(negedge clk); check("io_err_0202", bus_err, 1'b1);
    tick(); cpu_wr_n = 1'b1;

    do_sync(8'hA2, 16'hFB00);
    @(negedge clk);
`ifdef WAITSTATE_EN
    check("ws_ready_low", cpu_ready, 1'b0);
    n = 0;
    while (!cpu_ready && n < 40) begin tick(); @(negedge clk); n++; end
    check("ws_ready_back", cpu_ready, 1'b1);
    check("ws_ready_bounded", n < 40, 1'b1);
`else
    check("ws_ready_const", cpu_ready, 1'b1);
`endif

    for (int c = 0; c < 2000; c++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      cpu_addr  = {pages[$urandom_range(0, 8)], ($urandom_range(0, 3) == 0) ? 8'($urandom) : ports[$urandom_range(0, 5)]};
      cpu_sync  = ($urandom_range(0, 7) == 0);
      cpu_dout  = cpu_sync ? stats[$urandom_range(0, 7)] : 8'($urandom);
      cpu_dbin  = 1'($urandom_range(0, 1));
      cpu_wr_n  = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      io_rdata  = 16'($urandom);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
